score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter STEP, default 1: BCD points added per eat event; legal range 1..9.
REQ-002 Parameter BLANK_LZ, default 1: when 1, a leading-zero tens digit is driven as 4'hF, the blank code of the display stage.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 new_game  input  1  level; requests start/restart; synchronous to clk.
REQ-006 eat  input  1  level from game logic; each rising edge is one eat event; synchronous to clk.
REQ-007 game_over  input  1  level; ends current game; synchronous to clk.
REQ-008 num_1  output  4  current score tens digit (display slot 0).
REQ-009 num_2  output  4  current score ones digit (display slot 1).
REQ-010 num_3  output  4  high score tens digit (display slot 4).
REQ-011 num_4  output  4  high score ones digit (display slot 5).
REQ-012 playing  output  1  high while FSM is in PLAY.
REQ-013 new_record  output  1  high after a game ends with a score above the previous high score.

Function
REQ-014 FSM states: IDLE, PLAY, OVER; state, score, high score, eat_d and new_record are flops; num_1..num_4 and playing decode from flops only.
REQ-015 Score and high score are stored as two BCD digits each (tens, ones); each digit 0..9 at all times.
REQ-016 eat_d is eat delayed one clk; eat_rise = eat AND NOT eat_d; a held-high eat counts once.
REQ-017 IDLE: score held 0; new_game=1 -> PLAY with score 0.
REQ-018 PLAY, eat_rise=1, game_over=0, new_game=0: score <= score + STEP in BCD (ones wraps mod 10 with carry into tens); visible on outputs the edge after eat first samples high.
REQ-019 Saturation: if score + STEP > 99, score <= 99; score never wraps to 00.
REQ-020 PLAY, game_over=1: -> OVER on the same edge; eat_rise in that cycle ignored; new_game in that cycle ignored.
REQ-021 On the PLAY->OVER edge: if score > high score (decimal compare, tens then ones), high score <= score and new_record <= 1; equal score does not update.
REQ-022 PLAY, new_game=1, game_over=0: score <= 0, stay in PLAY, no high-score update, eat_rise ignored that cycle.
REQ-023 OVER: score frozen; eat ignored; new_game=1 -> PLAY with score <= 0 and new_record <= 0; game_over in OVER has no effect.
REQ-024 High score changes only per REQ-021; persists across games until rst.
REQ-025 BLANK_LZ=1: num_1 = 4'hF when score tens = 0, num_3 = 4'hF when high tens = 0; ones digits never blanked.
REQ-026 playing = 1 iff state = PLAY.

Reset
REQ-027 rst=1 forces immediately, without clk: state IDLE, score 00, high score 00, eat_d 0, new_record 0.
REQ-028 Outputs during/after reset: num_1 = 4'hF (BLANK_LZ=1) else 0, num_2 = 0, num_3 = 4'hF (BLANK_LZ=1) else 0, num_4 = 0, playing = 0.
REQ-029 rst asserted mid-PLAY or mid-OVER discards score and high score; after release FSM waits in IDLE for new_game.

Verification
REQ-030 Reset, new_game pulse, 12 single-cycle eat pulses (STEP=1) -> num_1=1, num_2=2, playing=1; 12 (count of 12) visible after last edge.
REQ-031 eat held high 20 cycles in PLAY -> score increments exactly once (00 -> 01).
REQ-032 STEP=7, score 95, one eat -> score 99; further eat -> stays 99.
REQ-033 Score 42, game_over with simultaneous eat edge -> OVER, score 42, high 42, new_record=1; new_game -> score 00 (num_1=F, num_2=0), new_record=0, high stays 42.
REQ-034 Second game ends at 42 (equal) -> high 42, new_record=0; game ends at 09 -> high 42 unchanged.
REQ-035 rst asserted asynchronously between clk edges mid-PLAY -> all outputs reach reset values before next edge; eat ignored until new_game.

Source files
------------

// File: rtl/score_keeper.sv
`default_nettype none
// ---------------------------------------------------------------------------
// score_keeper : two-digit BCD score / high-score keeper with IDLE/PLAY/OVER FSM
// Revision 1.0
// ---------------------------------------------------------------------------
module score_keeper #(
  parameter int STEP     = 1,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       eat,
  input  logic       game_over,
  output logic [3:0] num_1,
  output logic [3:0] num_2,
  output logic [3:0] num_3,
  output logic [3:0] num_4,
  output logic       playing,
  output logic       new_record
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] score_tens, score_ones;
  logic [3:0] high_tens, high_ones;
  logic       eat_d;

  logic       eat_rise;
  logic [4:0] ones_sum;
  logic       carry;
  logic [3:0] next_tens, next_ones;
  logic       score_gt_high;

  always_comb begin
    eat_rise  = eat & ~eat_d;
    ones_sum  = {1'b0, score_ones} + 5'(STEP);
    carry     = (ones_sum >= 5'd10);
    next_ones = carry ? 4'(ones_sum - 5'd10) : ones_sum[3:0];
    next_tens = score_tens + {3'd0, carry};
    // A carry out of tens 9 would exceed 99: pin to 99 instead of wrapping.
    if (carry && (score_tens == 4'd9)) begin
      next_tens = 4'd9;
      next_ones = 4'd9;
    end
    score_gt_high = (score_tens > high_tens) ||
                    ((score_tens == high_tens) && (score_ones > high_ones));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      score_tens <= 4'd0;
      score_ones <= 4'd0;
      high_tens  <= 4'd0;
      high_ones  <= 4'd0;
      eat_d      <= 1'b0;
      new_record <= 1'b0;
    end else begin
      eat_d <= eat;
      case (state)
        IDLE: begin
          score_tens <= 4'd0;
          score_ones <= 4'd0;
          if (new_game) begin
            state      <= PLAY;
            new_record <= 1'b0;
          end
        end
        PLAY: begin
          if (game_over) begin
            state <= OVER;
            if (score_gt_high) begin
              high_tens  <= score_tens;
              high_ones  <= score_ones;
              new_record <= 1'b1;
            end
          end else if (new_game) begin
            score_tens <= 4'd0;
            score_ones <= 4'd0;
          end else if (eat_rise) begin
            score_tens <= next_tens;
            score_ones <= next_ones;
          end
        end
        OVER: begin
          if (new_game) begin
            state      <= PLAY;
            score_tens <= 4'd0;
            score_ones <= 4'd0;
            new_record <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign num_1   = (BLANK_LZ && (score_tens == 4'd0)) ? 4'hF : score_tens;
  assign num_2   = score_ones;
  assign num_3   = (BLANK_LZ && (high_tens == 4'd0)) ? 4'hF : high_tens;
  assign num_4   = high_ones;
  assign playing = (state == PLAY);

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// Testbench for score_keeper: vector table, directed corner sequences and
// randomized traffic against an arithmetic reference model (STEP=1 and STEP=7).
module tb_score_keeper;

  logic clk, rst, new_game, eat, game_over;
  logic [3:0] a_n1, a_n2, a_n3, a_n4, b_n1, b_n2, b_n3, b_n4;
  logic a_play, a_nr, b_play, b_nr;

  score_keeper #(.STEP(1), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .eat(eat), .game_over(game_over),
    .num_1(a_n1), .num_2(a_n2), .num_3(a_n3), .num_4(a_n4),
    .playing(a_play), .new_record(a_nr));

  score_keeper #(.STEP(7), .BLANK_LZ(1'b1)) dut7 (
    .clk(clk), .rst(rst), .new_game(new_game), .eat(eat), .game_over(game_over),
    .num_1(b_n1), .num_2(b_n2), .num_3(b_n3), .num_4(b_n4),
    .playing(b_play), .new_record(b_nr));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;

  wire [17:0] out1 = {a_n1, a_n2, a_n3, a_n4, a_play, a_nr};
  wire [17:0] out7 = {b_n1, b_n2, b_n3, b_n4, b_play, b_nr};

  function automatic logic [17:0] o(int n1, int n2, int n3, int n4, int p, int nr);
    return {4'(n1), 4'(n2), 4'(n3), 4'(n4), 1'(p), 1'(nr)};
  endfunction

  task automatic chk(input string name, input logic [17:0] got, input logic [17:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (n1 n2 n3 n4 play rec)", name, got, exp);
    end
  endtask

  // Reference model: scores held as plain integers 0..99.
  int steps[2] = '{1, 7};
  int m_state[2];   // 0 idle, 1 play, 2 over
  int m_score[2];
  int m_high[2];
  int m_nr[2];
  int m_eatd[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0; m_score[i] = 0; m_high[i] = 0; m_nr[i] = 0; m_eatd[i] = 0;
    end
  endtask

  task automatic model_clock(input logic ng, input logic e, input logic go);
    for (int i = 0; i < 2; i++) begin
      int rise;
      rise = (e && m_eatd[i] == 0) ? 1 : 0;
      if (m_state[i] == 0) begin
        if (ng) begin m_state[i] = 1; m_score[i] = 0; m_nr[i] = 0; end
      end else if (m_state[i] == 1) begin
        if (go) begin
          m_state[i] = 2;
          if (m_score[i] > m_high[i]) begin m_high[i] = m_score[i]; m_nr[i] = 1; end
        end else if (ng) m_score[i] = 0;
        else if (rise == 1) m_score[i] = (m_score[i] + steps[i] > 99) ? 99 : m_score[i] + steps[i];
      end else begin
        if (ng) begin m_state[i] = 1; m_score[i] = 0; m_nr[i] = 0; end
      end
      m_eatd[i] = e ? 1 : 0;
    end
  endtask

  function automatic logic [17:0] exp_of(int i);
    int st, so, ht, ho;
    st = m_score[i] / 10; so = m_score[i] % 10;
    ht = m_high[i] / 10;  ho = m_high[i] % 10;
    return o(st == 0 ? 15 : st, so, ht == 0 ? 15 : ht, ho, m_state[i] == 1 ? 1 : 0, m_nr[i]);
  endfunction

  task automatic cyc(input logic ng, input logic e, input logic go);
    new_game = ng; eat = e; game_over = go;
    @(posedge clk);
    model_clock(ng, e, go);
    #1;
  endtask

  task automatic pulse_eat(input int n);
    repeat (n) begin
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  // Reset is raised between edges and released mid-cycle.
  task automatic do_reset();
    new_game = 1'b0; eat = 1'b0; game_over = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    @(posedge clk);
    #3 rst = 1'b0;
  endtask

  typedef struct {
    logic        ng;
    logic        e;
    logic        go;
    logic [17:0] exp;
  } vec_t;

  vec_t tbl[18];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, o(15, 0, 15, 0, 0, 0)};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, o(15, 0, 15, 0, 0, 0)};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, o(15, 0, 15, 0, 1, 0)};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, o(15, 1, 15, 0, 1, 0)};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, o(15, 1, 15, 0, 1, 0)};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, o(15, 1, 15, 0, 1, 0)};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, o(15, 2, 15, 0, 1, 0)};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, o(15, 2, 15, 0, 1, 0)};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, o(15, 0, 15, 0, 1, 0)};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, o(15, 0, 15, 0, 1, 0)};
    tbl[10] = '{1'b0, 1'b1, 1'b0, o(15, 1, 15, 0, 1, 0)};
    tbl[11] = '{1'b0, 1'b0, 1'b0, o(15, 1, 15, 0, 1, 0)};
    tbl[12] = '{1'b0, 1'b1, 1'b1, o(15, 1, 15, 1, 0, 1)};
    tbl[13] = '{1'b0, 1'b0, 1'b0, o(15, 1, 15, 1, 0, 1)};
    tbl[14] = '{1'b0, 1'b1, 1'b0, o(15, 1, 15, 1, 0, 1)};
    tbl[15] = '{1'b0, 1'b0, 1'b1, o(15, 1, 15, 1, 0, 1)};
    tbl[16] = '{1'b1, 1'b0, 1'b1, o(15, 0, 15, 1, 1, 0)};
    tbl[17] = '{1'b0, 1'b0, 1'b1, o(15, 0, 15, 1, 0, 0)};

    rst = 1'b1; new_game = 1'b0; eat = 1'b0; game_over = 1'b0;
    model_reset();
    #4;
    chk("reset_s1", out1, o(15, 0, 15, 0, 0, 0));
    chk("reset_s7", out7, o(15, 0, 15, 0, 0, 0));
    @(posedge clk);
    #3 rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].ng, tbl[i].e, tbl[i].go);
      chk($sformatf("vec%0d", i), out1, tbl[i].exp);
    end

    // Twelve single-cycle eats, then STEP=7 saturation on the second instance.
    do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    pulse_eat(12);
    chk("count12", out1, o(1, 2, 15, 0, 1, 0));
    chk("step7_84", out7, o(8, 4, 15, 0, 1, 0));
    pulse_eat(2);
    chk("step7_98", out7, o(9, 8, 15, 0, 1, 0));
    pulse_eat(1);
    chk("step7_sat99", out7, o(9, 9, 15, 0, 1, 0));
    pulse_eat(1);
    chk("step7_hold99", out7, o(9, 9, 15, 0, 1, 0));

    // Held eat counts once.
    cyc(1'b1, 1'b0, 1'b0);
    repeat (20) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("held_eat", out1, o(15, 1, 15, 0, 1, 0));

    // Score 42 ends with a simultaneous eat edge; then restart.
    cyc(1'b1, 1'b0, 1'b0);
    pulse_eat(42);
    cyc(1'b0, 1'b1, 1'b1);
    chk("over42_record", out1, o(4, 2, 4, 2, 0, 1));
    cyc(1'b1, 1'b0, 1'b0);
    chk("restart_after42", out1, o(15, 0, 4, 2, 1, 0));

    // Equal score and lower score leave the high score alone.
    pulse_eat(42);
    cyc(1'b0, 1'b0, 1'b1);
    chk("equal42", out1, o(4, 2, 4, 2, 0, 0));
    cyc(1'b1, 1'b0, 1'b0);
    pulse_eat(9);
    cyc(1'b0, 1'b0, 1'b1);
    chk("lower09", out1, o(15, 9, 4, 2, 0, 0));

    // Asynchronous reset between edges mid-PLAY.
    cyc(1'b1, 1'b0, 1'b0);
    pulse_eat(5);
    chk("pre_async", out1, o(15, 5, 4, 2, 1, 0));
    #2 rst = 1'b1;
    #1;
    chk("async_rst", out1, o(15, 0, 15, 0, 0, 0));
    @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
    pulse_eat(3);
    chk("idle_ignores_eat", out1, o(15, 0, 15, 0, 0, 0));

    // Randomized traffic against the reference model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 14) == 0));
      end
      chk("rand_s1", out1, exp_of(0));
      chk("rand_s7", out7, exp_of(1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
